dmem_responder: RTL and testbench

- Data-memory responder: the receiving end of the core's load/store requests (the mem_read/mem_write/func3 side emitted by the control path).
- Accepts one request at a time, performs byte/half/word access into internal word-wide storage, and returns sign/zero-extended load data.
- Returns error status for illegal accesses.
- Sits between the core datapath and on-chip block RAM on the Zybo Z7-20; the core stalls while req_ready is low.

---
 rtl/dmem_responder_pkg.sv | 72 +++++++
 rtl/dmem_bram.sv | 29 ++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: func3 encodings, FSM states,
// the load context captured at acceptance, and lane helpers.
package dmem_responder_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned LANES   = 4;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned OFF_W   = 2;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;
  localparam logic [F3_W-1:0] F3_SB  = 3'b000;
  localparam logic [F3_W-1:0] F3_SH  = 3'b001;
  localparam logic [F3_W-1:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [F3_W-1:0]  func3;
    logic [OFF_W-1:0] off;
  } load_ctx_t;

  // Byte-lane write enables for a store of the given size at the given offset.
  function automatic logic [LANES-1:0] byte_en(input logic [F3_W-1:0] func3,
                                               input logic [OFF_W-1:0] off);
    logic [LANES-1:0] be;
    be = '0;
    case (func3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [WORD_W-1:0] replicate(input logic [F3_W-1:0] func3,
                                                  input logic [WORD_W-1:0] wdata);
    logic [WORD_W-1:0] r;
    r = wdata;
    case (func3[1:0])
      2'b00:   r = {4{wdata[7:0]}};
      2'b01:   r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Select the addressed lane from a read word and extend it to 32 bits.
  function automatic logic [WORD_W-1:0] load_extend(input logic [WORD_W-1:0] word,
                                                    input load_ctx_t ctx);
    logic [WORD_W-1:0] sh;
    logic [WORD_W-1:0] r;
    sh = word >> {ctx.off, 3'b000};
    r  = sh;
    case (ctx.func3)
      F3_LB:   r = {{24{sh[7]}}, sh[7:0]};
      F3_LBU:  r = {24'd0, sh[7:0]};
      F3_LH:   r = {{16{sh[15]}}, sh[15:0]};
      F3_LHU:  r = {16'd0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Word-wide storage with per-byte write enables and a registered one-cycle read;
// written so that synthesis maps it onto block RAM (no reset on contents).
module dmem_bram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, accesses dmem_bram,
// returns extended load data or an error. `DMEM_MISALIGN_ERR_EN makes misaligned h/w accesses errors.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter int unsigned ADDR_LSB_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam int unsigned WIDX_W = 32 - ADDR_LSB_BITS;

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  load_ctx_t   ld_ctx_q, ld_ctx_d;

  logic             accept_c;
  logic             is_half_c, is_word_c;
  logic             bad_f3_c, range_err_c, req_err_c;
  logic [OFF_W-1:0] off_c;
  logic             mem_en_c;
  logic [3:0]       mem_be_c;
  logic [AW-1:0]    mem_addr_c;
  logic [31:0]      mem_wdata_c;
  logic [31:0]      mem_rdata;

  assign accept_c = req_valid & req_ready_q;

  // Request legality and effective lane offset, evaluated in the acceptance cycle.
  always_comb begin
    is_half_c   = (req_func3[1:0] == 2'b01);
    is_word_c   = (req_func3[1:0] == 2'b10);
    bad_f3_c    = req_write ? !(req_func3 inside {F3_SB, F3_SH, F3_SW})
                            : (req_func3 inside {3'b011, 3'b110, 3'b111});
    range_err_c = req_addr[31:ADDR_LSB_BITS] >= WIDX_W'(DEPTH_WORDS);
`ifdef DMEM_MISALIGN_ERR_EN
    req_err_c   = bad_f3_c | range_err_c |
                  (is_half_c & req_addr[0]) | (is_word_c & (|req_addr[1:0]));
    off_c       = req_addr[1:0];
`else
    req_err_c   = bad_f3_c | range_err_c;
    if (is_word_c)      off_c = 2'b00;
    else if (is_half_c) off_c = {req_addr[1], 1'b0};
    else                off_c = req_addr[1:0];
`endif
  end

  assign mem_en_c    = accept_c & ~req_err_c;
  assign mem_be_c    = (mem_en_c & req_write) ? byte_en(req_func3, off_c) : 4'b0000;
  assign mem_addr_c  = req_addr[AW+ADDR_LSB_BITS-1:ADDR_LSB_BITS];
  assign mem_wdata_c = replicate(req_func3, req_wdata);

  dmem_bram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_bram (
    .clk     (clk),
    .en_i    (mem_en_c),
    .we_i    (mem_be_c),
    .addr_i  (mem_addr_c),
    .wdata_i (mem_wdata_c),
    .rdata_o (mem_rdata)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    ld_ctx_d    = ld_ctx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          req_ready_d = 1'b0;
          if (req_err_c) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_write) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d        = ST_READ;
            ld_ctx_d.func3 = req_func3;
            ld_ctx_d.off   = off_c;
          end
        end
      end
      ST_READ: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_extend(mem_rdata, ld_ctx_q);
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      ld_ctx_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      ld_ctx_q    <= ld_ctx_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-array reference model predicts each
// response at issue time; a monitor checks data, error flag and latency.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_LSB_BITS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_func3 (req_func3),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    logic [31:0] rd;
    int          at;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  ref_mem [DEPTH*4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: byte-addressed memory and the access rules, in plain arithmetic.
  function automatic void model(input bit wr, input logic [31:0] a_in, input logic [31:0] wd,
                                input logic [2:0] f3, output bit err, output logic [31:0] rd);
    int unsigned nb;
    logic [31:0] a, v;
    a   = a_in;
    rd  = 32'd0;
    nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (wr) err = (f3 > 3'd2);
    else    err = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if ((a >> 2) >= DEPTH) err = 1'b1;
    if ((a % nb) != 0) begin
`ifdef DMEM_MISALIGN_ERR_EN
      err = 1'b1;
`else
      a = a - (a % nb);
`endif
    end
    if (err) return;
    if (wr) begin
      for (int i = 0; i < int'(nb); i++) ref_mem[a + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < int'(nb); i++) v = v | (32'(ref_mem[a + i]) << (8*i));
      if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rd = v;
    end
  endfunction

  // Drive one request once the responder is ready; optionally record its expected response.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input bit track);
    int waited;
    bit e;
    logic [31:0] r;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_func3 = f3;
    if (track) begin
      model(wr, a, wd, f3, e, r);
      sb_q.push_back('{err: e, rd: r, at: cyc + ((e || wr) ? 1 : 2)});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_func3 = 3'($urandom);
  endtask

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_rdata", rsp_rdata, e.rd);
        chk("rsp_latency", 32'(cyc), 32'(e.at));
      end
    end else if (rst && sb_q.size() > 0 && sb_q[0].at < cyc) begin
      e = sb_q.pop_front();
      chk("missing_rsp", 32'(rsp_valid), 32'd1);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin : stim
    int sel;
    logic [31:0] a;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_func3 = 3'd0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b1;

    for (int w = 0; w < int'(DEPTH); w++) issue(1'b1, 32'(w * 4), $urandom, SW, 1'b1);

    issue(1'b1, 32'h10, 32'hDEAD_BEEF, SW, 1'b1);
    issue(1'b0, 32'h10, 32'd0, LW, 1'b1);
    issue(1'b1, 32'h13, 32'h0000_0080, SB, 1'b1);
    issue(1'b0, 32'h13, 32'd0, LB, 1'b1);
    issue(1'b0, 32'h13, 32'd0, LBU, 1'b1);
    issue(1'b0, 32'h10, 32'd0, LW, 1'b1);
    issue(1'b1, 32'h12, 32'h0000_1234, SH, 1'b1);
    issue(1'b0, 32'h12, 32'd0, LH, 1'b1);
    issue(1'b0, 32'h10, 32'd0, LHU, 1'b1);
    issue(1'b0, 32'h11, 32'd0, LW, 1'b1);
    issue(1'b1, 32'h13, 32'hFFFF_5678, SH, 1'b1);
    issue(1'b0, 32'h10, 32'd0, LW, 1'b1);
    issue(1'b1, 32'(DEPTH * 4), 32'h1111_2222, SW, 1'b1);
    issue(1'b0, 32'h0, 32'd0, LW, 1'b1);
    issue(1'b0, 32'h0, 32'd0, 3'b011, 1'b1);
    issue(1'b1, 32'h4, 32'h5555_AAAA, 3'b100, 1'b1);
    issue(1'b0, 32'h4, 32'd0, LW, 1'b1);
    issue(1'b0, 32'hFFFF_FFFC, 32'd0, LW, 1'b1);

    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 15));
      if (sel == 0)     a = 32'(DEPTH * 4) + $urandom_range(0, 4095);
      else if (sel < 8) a = $urandom_range(0, 63);
      else              a = $urandom_range(0, DEPTH * 4 - 1);
      issue(1'($urandom), a, $urandom, 3'($urandom), 1'b1);
    end

    // Reset while a load sits in READ: no response, outputs cleared at once.
    issue(1'b0, 32'h10, 32'd0, LW, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_req_ready", 32'(req_ready), 32'd1);
    chk("midreset_rsp_rdata", rsp_rdata, 32'd0);
    chk("midreset_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    issue(1'b0, 32'h10, 32'd0, LW, 1'b1);
    issue(1'b0, 32'h12, 32'd0, LHU, 1'b1);

    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
